// File: rtl/cdb_arbiter_if.sv
// Port bundle for cdb_arbiter: ALU/LSU/MUL writeback handshakes in, registered CDB out.
// master = execution-unit side, slave = arbiter side.
interface cdb_arbiter_if #(
    parameter int ROB_IDX_W = 5,
    parameter int DATA_W    = 32
);
    logic                 alu_valid_i;
    logic                 alu_ready_o;
    logic [ROB_IDX_W-1:0] alu_rob_idx_i;
    logic [DATA_W-1:0]    alu_value_i;
    logic                 lsu_valid_i;
    logic                 lsu_ready_o;
    logic [ROB_IDX_W-1:0] lsu_rob_idx_i;
    logic [DATA_W-1:0]    lsu_value_i;
    logic                 mul_valid_i;
    logic                 mul_ready_o;
    logic [ROB_IDX_W-1:0] mul_rob_idx_i;
    logic [DATA_W-1:0]    mul_value_i;
    logic                 cdb_valid_o;
    logic [ROB_IDX_W-1:0] cdb_rob_idx_o;
    logic [DATA_W-1:0]    cdb_value_o;
    logic [1:0]           cdb_src_o;

    modport master (
        output alu_valid_i, alu_rob_idx_i, alu_value_i,
        output lsu_valid_i, lsu_rob_idx_i, lsu_value_i,
        output mul_valid_i, mul_rob_idx_i, mul_value_i,
        input  alu_ready_o, lsu_ready_o, mul_ready_o,
        input  cdb_valid_o, cdb_rob_idx_o, cdb_value_o, cdb_src_o
    );

    modport slave (
        input  alu_valid_i, alu_rob_idx_i, alu_value_i,
        input  lsu_valid_i, lsu_rob_idx_i, lsu_value_i,
        input  mul_valid_i, mul_rob_idx_i, mul_value_i,
        output alu_ready_o, lsu_ready_o, mul_ready_o,
        output cdb_valid_o, cdb_rob_idx_o, cdb_value_o, cdb_src_o
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Completion-bus arbiter: per-source FIFOs, one grant per cycle onto a registered CDB.
// Define CDB_FIXED_PRIO_EN for fixed priority MUL > LSU > ALU instead of round-robin.

module cdb_src_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush_i,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_ready,
    output logic         o_nempty,
    output logic [W-1:0] o_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    // ready looks only at the registered count, so a full FIFO refuses even while popping
    assign o_ready  = (r_cnt != CNT_W'(DEPTH));
    assign o_nempty = (r_cnt != '0);
    assign o_data   = r_mem[r_rd_ptr];
    assign w_push   = i_push & o_ready;
    assign w_pop    = i_pop & o_nempty;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !reset_i && !flush_i) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

module cdb_arbiter #(
    parameter int ROB_IDX_W  = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush_i,
    cdb_arbiter_if.slave bus
);
    localparam int NUM_SRC = 3;
    localparam int ENT_W   = ROB_IDX_W + DATA_W;

    logic [NUM_SRC-1:0]            w_push_vld;
    logic [NUM_SRC-1:0]            w_ready;
    logic [NUM_SRC-1:0]            w_nempty;
    logic [NUM_SRC-1:0]            w_pop;
    logic [NUM_SRC-1:0][ENT_W-1:0] w_push_data;
    logic [NUM_SRC-1:0][ENT_W-1:0] w_head;
    logic                          w_gnt_vld;
    logic [1:0]                    w_gnt_src;

    logic                 r_cdb_valid;
    logic [ROB_IDX_W-1:0] r_cdb_rob_idx;
    logic [DATA_W-1:0]    r_cdb_value;
    logic [1:0]           r_cdb_src;

    assign w_push_vld     = {bus.mul_valid_i, bus.lsu_valid_i, bus.alu_valid_i};
    assign w_push_data[0] = {bus.alu_rob_idx_i, bus.alu_value_i};
    assign w_push_data[1] = {bus.lsu_rob_idx_i, bus.lsu_value_i};
    assign w_push_data[2] = {bus.mul_rob_idx_i, bus.mul_value_i};
    assign bus.alu_ready_o = w_ready[0];
    assign bus.lsu_ready_o = w_ready[1];
    assign bus.mul_ready_o = w_ready[2];

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
            assign w_pop[g] = w_gnt_vld && (w_gnt_src == 2'(g));
            cdb_src_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clk_i    (clk_i),
                .reset_i  (reset_i),
                .flush_i  (flush_i),
                .i_push   (w_push_vld[g]),
                .i_data   (w_push_data[g]),
                .i_pop    (w_pop[g]),
                .o_ready  (w_ready[g]),
                .o_nempty (w_nempty[g]),
                .o_data   (w_head[g])
            );
        end
    endgenerate

`ifdef CDB_FIXED_PRIO_EN
    always_comb begin
        w_gnt_vld = |w_nempty;
        w_gnt_src = 2'd0;
        if (w_nempty[2])      w_gnt_src = 2'd2;
        else if (w_nempty[1]) w_gnt_src = 2'd1;
    end
`else
    logic [1:0] r_rr_ptr;
    logic [1:0] w_idx;

    // search ALU->LSU->MUL starting at the pointer; first non-empty head wins
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_src = 2'd0;
        w_idx     = 2'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_idx = 2'((int'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_gnt_vld && w_nempty[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_src = w_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_rr_ptr <= 2'd0;
        else if (w_gnt_vld && !flush_i)
            r_rr_ptr <= (w_gnt_src == 2'd2) ? 2'd0 : w_gnt_src + 2'd1;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cdb_valid   <= 1'b0;
            r_cdb_rob_idx <= '0;
            r_cdb_value   <= '0;
            r_cdb_src     <= 2'd0;
        end else if (flush_i || !w_gnt_vld) begin
            r_cdb_valid <= 1'b0;
        end else begin
            r_cdb_valid                  <= 1'b1;
            {r_cdb_rob_idx, r_cdb_value} <= w_head[w_gnt_src];
            r_cdb_src                    <= w_gnt_src;
        end
    end

    assign bus.cdb_valid_o   = r_cdb_valid;
    assign bus.cdb_rob_idx_o = r_cdb_rob_idx;
    assign bus.cdb_value_o   = r_cdb_value;
    assign bus.cdb_src_o     = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, arbitration order, streaming, flush, reset mid-stream.
module tb_cdb_arbiter;
    localparam int RW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [RW+DW-1:0] qa[$];
    logic [RW+DW-1:0] ql[$];
    logic [RW+DW-1:0] qm[$];

`ifdef CDB_FIXED_PRIO_EN
    int t3_src[3] = '{2, 1, 0};
    int t5_src[3] = '{2, 1, 0};
`else
    int t3_src[3] = '{0, 1, 2};
    int t5_src[3] = '{1, 2, 0};
`endif
    int t3_idx[3] = '{1, 3, 2};
    int t3_val[3] = '{5, 4, 9};

    cdb_arbiter_if #(.ROB_IDX_W(RW), .DATA_W(DW)) bus ();

    cdb_arbiter #(.ROB_IDX_W(RW), .DATA_W(DW), .FIFO_DEPTH(2)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [RW-1:0] idx, input logic [DW-1:0] val);
        case (s)
            0: begin bus.alu_valid_i = v; bus.alu_rob_idx_i = idx; bus.alu_value_i = val; end
            1: begin bus.lsu_valid_i = v; bus.lsu_rob_idx_i = idx; bus.lsu_value_i = val; end
            default: begin bus.mul_valid_i = v; bus.mul_rob_idx_i = idx; bus.mul_value_i = val; end
        endcase
    endtask

    task automatic idle_all();
        for (int s = 0; s < 3; s++) drive(s, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        idle_all();
        flush = 1'b0;
        rst   = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_cdb(input string tag, input int s, input int idx, input int val);
        chk({tag, "_vld"}, bus.cdb_valid_o, 1);
        chk({tag, "_src"}, bus.cdb_src_o, s);
        chk({tag, "_idx"}, bus.cdb_rob_idx_o, idx);
        chk({tag, "_val"}, bus.cdb_value_o, val);
    endtask

    task automatic chk_ready_all(input string tag);
        chk({tag, "_rdy"}, {bus.mul_ready_o, bus.lsu_ready_o, bus.alu_ready_o}, 3'b111);
    endtask

    // Compare a CDB beat against the front of the expected queue for its source
    task automatic sb_pop();
        logic [RW+DW-1:0] exp;
        int sz;
        if (bus.cdb_valid_o) begin
            case (bus.cdb_src_o)
                2'd0:    sz = qa.size();
                2'd1:    sz = ql.size();
                2'd2:    sz = qm.size();
                default: sz = 0;
            endcase
            if (sz == 0) begin
                chk("sb_extra", bus.cdb_valid_o, 0);
            end else begin
                case (bus.cdb_src_o)
                    2'd0:    exp = qa.pop_front();
                    2'd1:    exp = ql.pop_front();
                    default: exp = qm.pop_front();
                endcase
                chk("sb_data", {bus.cdb_rob_idx_o, bus.cdb_value_o}, exp);
            end
        end
    endtask

    initial begin
        int a, l, m;
        bit pa, pl, pm;
        idle_all();

        // 1: reset then idle
        do_reset();
        step();
        chk("t1_vld", bus.cdb_valid_o, 0);
        chk("t1_idx", bus.cdb_rob_idx_o, 0);
        chk("t1_val", bus.cdb_value_o, 0);
        chk("t1_src", bus.cdb_src_o, 0);
        chk_ready_all("t1");

        // 2: single ALU push, two-edge latency, then valid drops and data holds
        drive(0, 1'b1, 5'd0, 32'h5);
        step();
        idle_all();
        chk("t2_early_vld", bus.cdb_valid_o, 0);
        step();
        chk_cdb("t2", 0, 0, 5);
        step();
        chk("t2_after_vld", bus.cdb_valid_o, 0);
        chk("t2_hold_val", bus.cdb_value_o, 5);

        // 3/6: three sources push together from reset
        do_reset();
        drive(0, 1'b1, 5'd1, 32'h5);
        drive(1, 1'b1, 5'd3, 32'h4);
        drive(2, 1'b1, 5'd2, 32'h9);
        step();
        idle_all();
        chk("t3_early_vld", bus.cdb_valid_o, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            chk_cdb($sformatf("t3_beat%0d", i), t3_src[i], t3_idx[t3_src[i]], t3_val[t3_src[i]]);
            step();
        end
        chk("t3_end_vld", bus.cdb_valid_o, 0);

`ifndef CDB_FIXED_PRIO_EN
        // 4: all three stream; steady state rotates ALU,LSU,MUL and ALU is full 2 of 3 cycles
        do_reset();
        a = 0; l = 0; m = 0;
        for (int t = 0; t < 15; t++) begin
            chk($sformatf("t4_alu_rdy_c%0d", t), bus.alu_ready_o, (t < 3) ? 1 : (((t - 2) % 3) == 0));
            if (t >= 2) begin
                chk($sformatf("t4_vld_c%0d", t), bus.cdb_valid_o, 1);
                chk($sformatf("t4_src_c%0d", t), bus.cdb_src_o, (t - 2) % 3);
            end
            sb_pop();
            drive(0, 1'b1, 5'(a), 32'hA000_0000 + a);
            drive(1, 1'b1, 5'(l + 10), 32'hB000_0000 + l);
            drive(2, 1'b1, 5'(m + 20), 32'hC000_0000 + m);
            pa = bus.alu_ready_o; pl = bus.lsu_ready_o; pm = bus.mul_ready_o;
            step();
            if (pa) begin qa.push_back({5'(a), 32'hA000_0000 + a}); a++; end
            if (pl) begin ql.push_back({5'(l + 10), 32'hB000_0000 + l}); l++; end
            if (pm) begin qm.push_back({5'(m + 20), 32'hC000_0000 + m}); m++; end
        end
        idle_all();
        for (int t = 0; t < 8; t++) begin
            sb_pop();
            step();
        end
        chk("t4_alu_left", qa.size(), 0);
        chk("t4_lsu_left", ql.size(), 0);
        chk("t4_mul_left", qm.size(), 0);
        chk("t4_alu_pushes", a, 7);
`endif

        // 5: fill, flush with same-cycle pushes, then pointer survives the flush
        do_reset();
        for (int s = 0; s < 3; s++) drive(s, 1'b1, 5'(s + 1), 32'h11 + s);
        step();
        for (int s = 0; s < 3; s++) drive(s, 1'b1, 5'(s + 4), 32'h14 + s);
        step();
        chk_cdb("t5_pre", t3_src[0], t3_src[0] + 1, 32'h11 + t3_src[0]);
        for (int s = 0; s < 3; s++) drive(s, 1'b1, 5'(s + 7), 32'h17 + s);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_all();
        chk("t5_flush_vld", bus.cdb_valid_o, 0);
        chk("t5_hold_idx", bus.cdb_rob_idx_o, t3_src[0] + 1);
        chk_ready_all("t5_flush");
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t5_quiet%0d", i), bus.cdb_valid_o, 0);
        end
        for (int s = 0; s < 3; s++) drive(s, 1'b1, 5'(s + 10), 32'h20 + s);
        step();
        idle_all();
        step();
        for (int i = 0; i < 3; i++) begin
            chk_cdb($sformatf("t5_post%0d", i), t5_src[i], t5_src[i] + 10, 32'h20 + t5_src[i]);
            step();
        end
        chk("t5_end_vld", bus.cdb_valid_o, 0);

        // reset mid-stream drops pending results
        for (int s = 0; s < 3; s++) drive(s, 1'b1, 5'(s + 13), 32'h30 + s);
        step();
        idle_all();
        step();
        chk("t7_pre_vld", bus.cdb_valid_o, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t7_rst_vld", bus.cdb_valid_o, 0);
        chk("t7_rst_idx", bus.cdb_rob_idx_o, 0);
        chk("t7_rst_val", bus.cdb_value_o, 0);
        chk("t7_rst_src", bus.cdb_src_o, 0);
        chk_ready_all("t7");
        step();
        step();
        chk("t7_drop_vld", bus.cdb_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
